// File: rtl/control_registros_rtc.sv
// control_registros_rtc: sequences transfers between the RTC bus interface
// and the nine VGA display registers. It runs a periodic read scan of all
// RTC registers and serves user write requests, which take priority.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start_wr, wr_data       user write request and edited value for wr_index
//   rd_data, bus_ack        RTC read data and one-cycle completion pulse
//   bus_req, bus_rw,        transfer request, 1=read/0=write, register
//   bus_addr, bus_wdata     address and write data to the RTC bus interface
//   wr_index                index (0..8) of the register being written
//   dseg, load_en           data bus and one-hot enables for display registers
//   EN, ACT                 read-load / write-load strobes
//   seleccion               0 = read scan, 1 = write sequence
//   busy, timeout_err       not idle; sticky bus-timeout flag
module control_registros_rtc #(
  parameter int unsigned REFRESH_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_wr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  input  logic       bus_ack,
  output logic       bus_req,
  output logic       bus_rw,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic [3:0] wr_index,
  output logic [7:0] dseg,
  output logic [8:0] load_en,
  output logic       EN,
  output logic       ACT,
  output logic       seleccion,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned RW = $clog2(REFRESH_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_LOAD, S_NEXT} state_t;

  // RTC register address for each display index
  function automatic logic [7:0] addr_of(input logic [3:0] i);
    case (i)
      4'd0:    addr_of = 8'h21;
      4'd1:    addr_of = 8'h22;
      4'd2:    addr_of = 8'h23;
      4'd3:    addr_of = 8'h24;
      4'd4:    addr_of = 8'h25;
      4'd5:    addr_of = 8'h26;
      4'd6:    addr_of = 8'h41;
      4'd7:    addr_of = 8'h42;
      default: addr_of = 8'h43;
    endcase
  endfunction

  state_t        state, state_nx;
  logic [RW-1:0] refresh_cnt, refresh_nx;
  logic [TW-1:0] wait_cnt, wait_nx;
  logic [3:0]    idx, idx_nx;
  logic          pending, pending_nx;
  logic          req_nx, rw_nx, en_nx, act_nx, sel_nx, busy_nx, terr_nx;
  logic [7:0]    addr_nx, wdata_nx, dseg_nx;
  logic [3:0]    widx_nx;
  logic [8:0]    load_nx;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      refresh_cnt <= '0;
      wait_cnt    <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      bus_req     <= 1'b0;
      bus_rw      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      wr_index    <= '0;
      dseg        <= '0;
      load_en     <= '0;
      EN          <= 1'b0;
      ACT         <= 1'b0;
      seleccion   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      refresh_cnt <= refresh_nx;
      wait_cnt    <= wait_nx;
      idx         <= idx_nx;
      pending     <= pending_nx;
      bus_req     <= req_nx;
      bus_rw      <= rw_nx;
      bus_addr    <= addr_nx;
      bus_wdata   <= wdata_nx;
      wr_index    <= widx_nx;
      dseg        <= dseg_nx;
      load_en     <= load_nx;
      EN          <= en_nx;
      ACT         <= act_nx;
      seleccion   <= sel_nx;
      busy        <= busy_nx;
      timeout_err <= terr_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx   = state;
    refresh_nx = refresh_cnt;
    wait_nx    = wait_cnt;
    idx_nx     = idx;
    pending_nx = pending;
    req_nx     = bus_req;
    rw_nx      = bus_rw;
    addr_nx    = bus_addr;
    wdata_nx   = bus_wdata;
    widx_nx    = wr_index;
    dseg_nx    = dseg;
    load_nx    = '0;
    en_nx      = 1'b0;
    act_nx     = 1'b0;
    sel_nx     = seleccion;
    terr_nx    = timeout_err;

    // A write request during a read scan is remembered; during a write it is dropped
    if (state != S_IDLE && start_wr && !seleccion) pending_nx = 1'b1;

    case (state)
      S_IDLE: begin
        refresh_nx = refresh_cnt + RW'(1);
        if (start_wr || pending) begin
          state_nx   = S_REQ;
          sel_nx     = 1'b1;
          idx_nx     = '0;
          pending_nx = 1'b0;
          refresh_nx = '0;
          terr_nx    = 1'b0;
        end else if (refresh_cnt == RW'(REFRESH_CYCLES - 1)) begin
          state_nx   = S_REQ;
          sel_nx     = 1'b0;
          idx_nx     = '0;
          refresh_nx = '0;
          terr_nx    = 1'b0;
        end
      end
      S_REQ: begin
        req_nx  = 1'b1;
        rw_nx   = ~seleccion;
        addr_nx = addr_of(idx);
        if (seleccion) begin
          wdata_nx = wr_data;
          widx_nx  = idx;
        end
        wait_nx  = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (bus_ack) begin
          req_nx   = 1'b0;
          dseg_nx  = seleccion ? bus_wdata : rd_data;
          load_nx  = 9'(1) << idx;
          en_nx    = ~seleccion;
          act_nx   = seleccion;
          state_nx = S_LOAD;
        end else if (wait_cnt >= TW'(TIMEOUT_CYCLES)) begin
          req_nx   = 1'b0;
          terr_nx  = 1'b1;
          state_nx = S_NEXT;
        end else begin
          wait_nx = wait_cnt + TW'(1);
        end
      end
      S_LOAD: state_nx = S_NEXT;
      S_NEXT: begin
        if (idx == 4'd8) begin
          state_nx = S_IDLE;
        end else begin
          idx_nx   = idx + 4'd1;
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    busy_nx = (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_control_registros_rtc.sv
// Directed self-checking bench for control_registros_rtc (REFRESH_CYCLES=10,
// TIMEOUT_CYCLES=5). A responder acks each request one cycle after it rises
// and returns rd_data = 0x10 + index; a negedge monitor logs transfers/loads.
module tb_control_registros_rtc;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_wr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       bus_ack;
  logic       bus_req, bus_rw;
  logic [7:0] bus_addr, bus_wdata;
  logic [3:0] wr_index;
  logic [7:0] dseg;
  logic [8:0] load_en;
  logic       EN, ACT, seleccion, busy, timeout_err;

  control_registros_rtc #(.REFRESH_CYCLES(10), .TIMEOUT_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .start_wr(start_wr), .wr_data(wr_data),
    .rd_data(rd_data), .bus_ack(bus_ack), .bus_req(bus_req), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .wr_index(wr_index),
    .dseg(dseg), .load_en(load_en), .EN(EN), .ACT(ACT),
    .seleccion(seleccion), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] widx;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  typedef struct packed {
    logic       en;
    logic       act;
    logic       sel;
    logic [8:0] le;
    logic [7:0] d;
  } ld_t;

  logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  txn_t txq[$];
  ld_t  ldq[$];
  logic prev_req = 1'b0;
  int   bad_cnt = 0;
  int   hold_cnt = 0;
  int   n_checks = 0;
  int   n_err = 0;

  logic       resp_on = 1'b1;
  logic       force_ack = 1'b0;
  logic [7:0] hold_addr = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] idx_of(input logic [7:0] a);
    logic [7:0] r = 8'h0;
    for (int i = 0; i < 9; i++) if (addr_tab[i] == a) r = 8'(i);
    return r;
  endfunction

  // Bus responder: runs just after the negedge so it sees stimulus flags set there
  initial begin
    bus_ack = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (force_ack || (resp_on && bus_req && !bus_ack && bus_addr != hold_addr)) begin
        bus_ack = 1'b1;
        rd_data = 8'h10 + idx_of(bus_addr);
      end else begin
        bus_ack = 1'b0;
      end
    end
  end

  // Monitor: logs rising requests and every load strobe, checks strobe shape
  always @(negedge clk) begin
    prev_req <= bus_req;
    if (bus_req && !prev_req) txq.push_back('{wr_index, bus_rw, bus_addr, bus_wdata});
    if (load_en != 9'd0) ldq.push_back('{EN, ACT, seleccion, load_en, dseg});
    if ((EN || ACT || load_en != 9'd0) && !((EN ^ ACT) && $onehot(load_en)))
      bad_cnt <= bad_cnt + 1;
    if (hold_addr != 8'h00 && bus_req && bus_addr == hold_addr) hold_cnt <= hold_cnt + 1;
  end

  task automatic wait_busy(input logic lvl, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== lvl && n < max);
    if (busy !== lvl) chk("wait_busy_bound", 64'(busy), 64'(lvl));
  endtask

  int n, bt, bl;
  logic [8:0] seen;

  initial begin
    reset = 1'b1; start_wr = 1'b0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus_req, bus_rw, bus_addr, bus_wdata, wr_index, dseg, load_en,
                          EN, ACT, seleccion, busy, timeout_err}, 64'd0);

    // Automatic read scan after 10 idle cycles
    reset = 1'b0;
    wait_busy(1'b1, 50, n);
    chk("scan_start_cycles", 64'(n), 64'd10);
    chk("scan_is_read", 64'(seleccion), 64'd0);
    bt = txq.size(); bl = ldq.size();
    wait_busy(1'b0, 200, n);
    chk("scan_len", 64'(n), 64'd36);
    chk("scan_txn_count", 64'(txq.size() - bt), 64'd9);
    chk("scan_load_count", 64'(ldq.size() - bl), 64'd9);
    for (int i = 0; i < 9; i++) begin
      chk("rd_addr", 64'(txq[bt+i].addr), 64'(addr_tab[i]));
      chk("rd_rw", 64'(txq[bt+i].rw), 64'd1);
      chk("rd_load_en", 64'(ldq[bl+i].le), 64'(9'(1) << i));
      chk("rd_dseg", 64'(ldq[bl+i].d), 64'(8'h10 + 8'(i)));
      chk("rd_en_act", {ldq[bl+i].en, ldq[bl+i].act, ldq[bl+i].sel}, 64'b100);
    end
    chk("dseg_held", 64'(dseg), 64'h18);
    chk("no_timeout", 64'(timeout_err), 64'd0);

    // User write from IDLE
    wr_data = 8'h59; start_wr = 1'b1;
    bt = txq.size(); bl = ldq.size();
    @(negedge clk); start_wr = 1'b0;
    wait_busy(1'b0, 200, n);
    chk("wr_load_count", 64'(ldq.size() - bl), 64'd9);
    for (int i = 0; i < 9; i++) begin
      chk("wr_addr", 64'(txq[bt+i].addr), 64'(addr_tab[i]));
      chk("wr_rw_wdata", {txq[bt+i].rw, txq[bt+i].wdata}, 64'h059);
      chk("wr_index", 64'(txq[bt+i].widx), 64'(i));
      chk("wr_load_en", 64'(ldq[bl+i].le), 64'(9'(1) << i));
      chk("wr_dseg", 64'(ldq[bl+i].d), 64'h59);
      chk("wr_en_act", {ldq[bl+i].en, ldq[bl+i].act, ldq[bl+i].sel}, 64'b011);
    end

    // start_wr coincident with refresh expiry: write wins
    repeat (9) @(negedge clk);
    wr_data = 8'h33; start_wr = 1'b1;
    bt = txq.size();
    @(negedge clk); start_wr = 1'b0;
    chk("coinc_busy_sel", {busy, seleccion}, 64'b11);
    wait_busy(1'b0, 200, n);
    chk("coinc_first_rw", 64'(txq[bt].rw), 64'd0);
    wait_busy(1'b1, 50, n);
    chk("read_after_write_cycles", 64'(n), 64'd10);
    chk("read_after_write_sel", 64'(seleccion), 64'd0);

    // start_wr during read index 4: scan completes, then write 1 cycle after IDLE
    bl = ldq.size();
    wr_data = 8'hA5;
    n = 0;
    while (!(bus_req && bus_addr == 8'h25) && n < 100) begin @(negedge clk); n++; end
    chk("found_index4", 64'(bus_addr), 64'h25);
    start_wr = 1'b1;
    @(negedge clk); start_wr = 1'b0;
    wait_busy(1'b0, 200, n);
    wait_busy(1'b1, 10, n);
    chk("pending_gap", 64'(n), 64'd1);
    chk("pending_is_write", 64'(seleccion), 64'd1);
    wait_busy(1'b0, 200, n);
    chk("pend_load_count", 64'(ldq.size() - bl), 64'd18);
    for (int i = 0; i < 9; i++) begin
      chk("pend_rd", {ldq[bl+i].en, ldq[bl+i].act, ldq[bl+i].le, ldq[bl+i].d},
          {2'b10, 9'(1) << i, 8'h10 + 8'(i)});
      chk("pend_wr", {ldq[bl+9+i].en, ldq[bl+9+i].act, ldq[bl+9+i].le, ldq[bl+9+i].d},
          {2'b01, 9'(1) << i, 8'hA5});
    end

    // Timeout on index 2
    hold_addr = 8'h23;
    wait_busy(1'b1, 50, n);
    chk("to_scan_start", 64'(n), 64'd10);
    bt = txq.size(); bl = ldq.size();
    wait_busy(1'b0, 200, n);
    chk("timeout_err_set", 64'(timeout_err), 64'd1);
    chk("to_load_count", 64'(ldq.size() - bl), 64'd8);
    seen = '0;
    for (int i = bl; i < ldq.size(); i++) seen = seen | ldq[i].le;
    chk("to_no_bit2", 64'(seen), 64'h1FB);
    chk("to_idx3_addr", 64'(txq[bt+3].addr), 64'h24);
    chk("to_idx3_load", {ldq[bl+2].le, ldq[bl+2].d}, {9'h008, 8'h13});
    chk("to_req_len_ok", 64'(hold_cnt >= 5 && hold_cnt <= 8), 64'd1);

    // timeout_err clears at next scan; then reset in WAIT
    hold_addr = 8'h00; resp_on = 1'b0;
    wait_busy(1'b1, 50, n);
    chk("timeout_err_cleared", 64'(timeout_err), 64'd0);
    @(negedge clk);
    chk("in_wait_req", 64'(bus_req), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {bus_req, busy, load_en, dseg, EN, ACT}, 64'd0);
    reset = 1'b0;
    bl = ldq.size();
    force_ack = 1'b1;
    @(negedge clk); force_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_ack_no_load", 64'(ldq.size() - bl), 64'd0);
    chk("late_ack_idle", {busy, bus_req}, 64'd0);
    chk("strobe_shape", 64'(bad_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
